fetch_stage_q: RTL and testbench
================================

Name: fetch_stage_q

Overview:
- Parametrised IF stage with a prefetch queue, a req/gnt/rvalid instruction-memory handshake, a decode stall and a branch redirect.
- Decouples a variable-latency instruction memory from decode.
- Drives the IF/ID pipeline register outputs InstrD/PCD/PCPlus4D plus an explicit ValidD.
- Redirect (PCSrcE) flushes the queue and discards in-flight wrong-path responses.

Parameters:
- XLEN, 32, PC/address width.
- DEPTH, 4, prefetch queue entries and max outstanding requests; power of 2, >=2.
- RESET_PC, 0, PCF value after reset.
- ILEN, 32, instruction width; PC increment is fixed at 4.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- PCSrcE  in  1  redirect request from execute.
- PCTargetE  in  XLEN  redirect target.
- StallD  in  1  decode cannot accept; hold IF/ID register.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (=PCF).
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req).
- imem_rvalid  in  1  in-order response valid, latency >=1 cycle after gnt.
- imem_rdata  in  ILEN  response instruction.
- InstrD  out  ILEN  decode instruction, 0 when ValidD=0.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4, mod 2^XLEN.
- ValidD  out  1  IF/ID register holds a valid instruction.
- occupancy  out  $clog2(DEPTH)+1  instruction queue entries.

Behaviour:
- Reset (rst=0, async): PCF=RESET_PC; queue, pending-PC FIFO, outstanding count and drop count all 0; ValidD=0, InstrD=0, PCD=0, PCPlus4D=0, imem_req=0. The memory must be reset in the same period.
- Credit: imem_req = (occupancy + outstanding < DEPTH) & !PCSrcE & rst; imem_addr=PCF.
- Accepted request (req & gnt): PCF <= PCF+4 (wraps at 2^XLEN), push PCF into the pending-PC FIFO, outstanding+1.
- Response (imem_rvalid): pop the pending-PC FIFO, outstanding-1.
  - If drop count=0, push {imem_rdata, pc, pc+4} into the queue.
  - Otherwise drop count-1 and discard the response.
  - rvalid with outstanding=0 is a protocol error: ignore it, no state change.
- Queue: circular, DEPTH entries. Credit rule guarantees no overflow. Simultaneous push and pop keep occupancy constant.
- IF/ID register:
  - If ValidD=1 & StallD=1: hold all outputs.
  - Else if queue non-empty: load head, pop, ValidD=1.
  - Else: ValidD=0, InstrD=0, PCD/PCPlus4D hold.
  - StallD with ValidD=0 does not block a load.
- Latency: rvalid sampled at edge k (drop count 0, empty queue, no stall) -> ValidD=1 after edge k+1. Back-to-back responses sustain 1 instr/cycle.
- Redirect (PCSrcE=1 at edge), takes priority over all other events:
  - PCF <= PCTargetE; queue cleared, occupancy=0.
  - IF/ID cleared (ValidD=0, InstrD=0) regardless of StallD.
  - drop count <= outstanding - (imem_rvalid ? 1 : 0); a same-cycle response is discarded and its pending PC popped.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: last one wins; drop count is recomputed each time from the current outstanding count.
- Mid-operation reset: immediate clear. Outputs read 0/invalid from assertion; first request issues on the first edge after deassert.

Test Plan:
- Reset release, RESET_PC=0x100, gnt=1 always, latency 1: ValidD sequence PCD=0x100,0x104,0x108…, PCPlus4D=PCD+4, InstrD=rdata per address. Steady state is one instruction per cycle.
- gnt=1, StallD=1 held 10 cycles, DEPTH=4: occupancy saturates at 4 and imem_req drops. Outputs hold the first instruction. Releasing StallD drains in order with no loss or duplicate.
- Latency 3 with 3 requests outstanding, PCSrcE=1, PCTargetE=0x200: the 3 old responses are dropped. First ValidD shows PCD=0x200. ValidD=0 in the cycle after the redirect.
- PCSrcE coinciding with imem_rvalid and with StallD=1 and ValidD=1: the response is discarded, IF/ID is cleared, drop count=outstanding-1, and the next valid PCD equals the target.
- PCF=0xFFFFFFFC, XLEN=32: next fetch address is 0x00000000 and PCPlus4D=0x00000000.
- rst pulsed low mid-stream, asynchronously between edges: outputs go 0 immediately with occupancy=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_q.sv
// Instruction fetch stage: prefetch queue between a req/gnt/rvalid memory and the IF/ID register.
// Latency: a response sampled at edge k appears in IF/ID after edge k+1; 1 instr/cycle sustained.
// Backpressure: StallD holds IF/ID; requests stop once queued + outstanding reaches DEPTH.
module fetch_stage_q #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ILEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCSrcE,
  input  logic [XLEN-1:0]          PCTargetE,
  input  logic                     StallD,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [ILEN-1:0]          imem_rdata,
  output logic [ILEN-1:0]          InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic                     ValidD,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  // Fetch PC and request bookkeeping
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [CW-1:0]   out_q, out_d;     // requests granted but not yet answered
  logic [CW-1:0]   drop_q, drop_d;   // wrong-path responses still to discard

  // Pending-PC FIFO: PC of each outstanding request, in grant order
  logic [XLEN-1:0] pend_pc_q [DEPTH];
  logic [AW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;

  // Prefetch queue
  logic [ILEN-1:0] q_instr_q [DEPTH];
  logic [XLEN-1:0] q_pc_q    [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   occ_q, occ_d;

  // IF/ID register
  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d, pcp4_q, pcp4_d;

  logic credit_ok, acc, rsp, push, pop;

  assign credit_ok = ({1'b0, occ_q} + {1'b0, out_q}) < DEPTH_W;
  assign imem_req  = credit_ok & ~PCSrcE & rst;
  assign imem_addr = pcf_q;
  assign acc       = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol violation and is ignored
  assign rsp       = imem_rvalid & (out_q != '0);
  assign push      = rsp & (drop_q == '0) & ~PCSrcE;
  assign pop       = ~PCSrcE & ~(valid_q & StallD) & (occ_q != '0);

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;
  assign occupancy = occ_q;

  // Next-state: redirect overrides every other event in the same cycle
  always_comb begin
    pcf_d     = pcf_q;
    out_d     = out_q + CW'(acc) - CW'(rsp);
    drop_d    = drop_q;
    pend_wr_d = pend_wr_q + AW'(acc);
    pend_rd_d = pend_rd_q + AW'(rsp);
    head_d    = head_q + AW'(pop);
    tail_d    = tail_q + AW'(push);
    occ_d     = occ_q + CW'(push) - CW'(pop);
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcp4_d    = pcp4_q;

    if (PCSrcE) begin
      pcf_d   = PCTargetE;
      // Everything still in flight belongs to the old path; acc is 0 here
      drop_d  = out_q - CW'(rsp);
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      valid_d = 1'b0;
      instr_d = '0;
    end else begin
      if (acc) pcf_d = pcf_q + XLEN'(4);
      if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (!(valid_q && StallD)) begin
        if (occ_q != '0) begin
          valid_d = 1'b1;
          instr_d = q_instr_q[head_q];
          pcd_d   = q_pc_q[head_q];
          pcp4_d  = q_pc_q[head_q] + XLEN'(4);
        end else begin
          valid_d = 1'b0;
          instr_d = '0;
        end
      end
    end
  end

  // Control state with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf_q     <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pcd_q     <= '0;
      pcp4_q    <= '0;
    end else begin
      pcf_q     <= pcf_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
    end
  end

  // Storage arrays: contents are only read behind valid pointers, so no reset
  always_ff @(posedge clk) begin
    if (acc) pend_pc_q[pend_wr_q] <= pcf_q;
    if (push) begin
      q_instr_q[tail_q] <= imem_rdata;
      q_pc_q[tail_q]    <= pend_pc_q[pend_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_stage_q.sv
// Bench for fetch_stage_q: memory model with per-request latency plus a PC-stream scoreboard.
module tb_fetch_stage_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_stage_q #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .occupancy(occupancy)
  );

  typedef struct { int unsigned due; logic [31:0] addr; } req_t;
  req_t        mq[$];
  int          total = 0, bad = 0;
  int unsigned cyc_n = 0, last_due = 0;
  int unsigned lat = 1;
  bit          spurious = 1'b0;
  logic [31:0] exp_pc = 32'h100, held_pc = 32'h0;
  logic        pv = 1'b0;
  int          delivered = 0;
  bit          wrap_seen = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, capture handshake, clock, update model, check IF/ID
  task automatic cyc();
    logic rv, acc, redir, st;
    logic [31:0] aa, tgt;
    int unsigned due;
    if (spurious) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    end else if (mq.size() > 0 && mq[0].due <= cyc_n + 1) begin
      imem_rvalid = 1'b1; imem_rdata = memf(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    rv = imem_rvalid && !spurious;
    acc = imem_req && imem_gnt;
    aa = imem_addr;
    redir = PCSrcE;
    tgt = PCTargetE;
    st = StallD;
    if (redir) chk("req_in_redirect", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    cyc_n++;
    if (rv) void'(mq.pop_front());
    if (acc) begin
      due = cyc_n + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due: due, addr: aa});
      chk("pcf_next", imem_addr, aa + 32'd4);
    end
    if (redir) begin
      exp_pc = tgt;
      chk("redir_valid", {31'b0, ValidD}, 32'd0);
      chk("redir_instr", InstrD, 32'd0);
    end else if (pv && st) begin
      chk("hold_valid", {31'b0, ValidD}, 32'd1);
      chk("hold_pcd", PCD, held_pc);
      chk("hold_instr", InstrD, memf(held_pc));
    end else if (ValidD) begin
      chk("pcd", PCD, exp_pc);
      chk("instr", InstrD, memf(exp_pc));
      chk("pcplus4", PCPlus4D, exp_pc + 32'd4);
      if (exp_pc == 32'hFFFF_FFFC && PCPlus4D == 32'h0) wrap_seen = 1'b1;
      held_pc = exp_pc;
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      chk("idle_instr", InstrD, 32'd0);
    end
    chk("occ_range", {31'b0, occupancy <= 3'd4}, 32'd1);
    pv = ValidD;
  endtask

  initial begin
    int d0;
    bit found;
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, 32'd0);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4", PCPlus4D, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_occ", {29'b0, occupancy}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);

    // Streaming with latency 1: one instruction per cycle in steady state
    lat = 1;
    repeat (10) cyc();
    d0 = delivered;
    repeat (20) cyc();
    chk("steady_rate", delivered - d0, 32'd20);

    // Decode stall: queue saturates, requests stop, then drain in order
    StallD = 1'b1;
    repeat (10) cyc();
    chk("stall_occ", {29'b0, occupancy}, 32'd4);
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, ValidD}, 32'd1);
    StallD = 1'b0;
    d0 = delivered;
    repeat (12) cyc();
    chk("drain_rate", delivered - d0, 32'd12);

    // Redirect with three requests outstanding at latency 3
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (mq.size() == 3) found = 1'b1;
    end
    chk("three_outstanding", {31'b0, found}, 32'd1);
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    cyc();
    PCSrcE = 1'b0;
    cyc();
    chk("after_redir_valid", {31'b0, ValidD}, 32'd0);
    d0 = delivered;
    repeat (15) cyc();
    chk("redir_progress", {31'b0, delivered > d0}, 32'd1);

    // Redirect coinciding with a response, a stall and a valid IF/ID entry
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (ValidD && mq.size() > 0 && mq[0].due <= cyc_n + 1) begin
        StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        found = 1'b1;
      end
      cyc();
      StallD = 1'b0; PCSrcE = 1'b0;
    end
    chk("coincide_found", {31'b0, found}, 32'd1);
    d0 = delivered;
    repeat (15) cyc();
    chk("coincide_progress", {31'b0, delivered > d0}, 32'd1);

    // Address wrap at the top of the 32-bit space
    lat = 1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    cyc();
    PCSrcE = 1'b0;
    repeat (8) cyc();
    chk("wrap_seen", {31'b0, wrap_seen}, 32'd1);

    // Response with nothing outstanding is ignored
    imem_gnt = 1'b0;
    repeat (8) cyc();
    chk("drained_occ", {29'b0, occupancy}, 32'd0);
    chk("drained_valid", {31'b0, ValidD}, 32'd0);
    spurious = 1'b1;
    cyc();
    spurious = 1'b0;
    chk("spurious_occ", {29'b0, occupancy}, 32'd0);
    cyc();
    chk("spurious_valid", {31'b0, ValidD}, 32'd0);
    imem_gnt = 1'b1;
    d0 = delivered;
    repeat (10) cyc();
    chk("post_spurious_progress", {31'b0, delivered > d0}, 32'd1);

    // Randomised traffic: grant gaps, stalls, variable latency, redirects
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      StallD = ($urandom_range(0, 3) == 0);
      lat = $urandom_range(1, 4);
      PCSrcE = ($urandom_range(0, 24) == 0);
      PCTargetE = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    PCSrcE = 1'b0; StallD = 1'b0; imem_gnt = 1'b1; lat = 1;
    chk("random_progress", {31'b0, delivered > d0 + 100}, 32'd1);

    // Asynchronous reset mid-stream
    repeat (5) cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, ValidD}, 32'd0);
    chk("mid_rst_instr", InstrD, 32'd0);
    chk("mid_rst_pcd", PCD, 32'd0);
    chk("mid_rst_occ", {29'b0, occupancy}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    mq.delete();
    last_due = 0;
    pv = 1'b0;
    exp_pc = 32'h100;
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_addr", imem_addr, 32'h100);
    d0 = delivered;
    repeat (20) cyc();
    chk("restart_progress", {31'b0, delivered > d0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
